// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment value formatter.
// Holds the FSM encoding, digit geometry, default enable masks and the leading-digit encoder.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HEX   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 4;
  localparam int BCD_DIGITS = 5;
  localparam int BCD_W      = BCD_DIGITS * DIGIT_W;
  localparam int VALUE_W    = 16;

  localparam logic [NUM_DIGITS-1:0] EN_MASK_DEC = 8'h1F;
  localparam logic [NUM_DIGITS-1:0] EN_MASK_HEX = 8'h0F;

  // Enable every digit up to the most significant non-zero nibble; digit 0 is always lit.
  function automatic logic [NUM_DIGITS-1:0] lead_enable(
    input logic [NUM_DIGITS*DIGIT_W-1:0] data
  );
    logic [NUM_DIGITS-1:0] mask;
    logic                  seen;
    seen = 1'b0;
    mask = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen    = seen | (data[i*DIGIT_W +: DIGIT_W] != 4'h0) | (i == 0);
      mask[i] = seen;
    end
    return mask;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One double-dabble correction stage: a BCD digit of 5 or more gets 3 added
// so the following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
  import display_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/display_value_formatter.sv
// Converts a 16-bit value into eight digit codes plus enable/dot masks for the 7-segment driver.
// Decimal uses a bit-serial double-dabble; outputs change only in the DONE cycle.
module display_value_formatter
  import display_pkg::*;
#(
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_resetn,
  input  logic [VALUE_W-1:0]            i_value,
  input  logic                          i_valid,
  input  logic                          i_signed,
  input  logic                          i_hexMode,
  input  logic [NUM_DIGITS-1:0]         i_dots,
  output logic                          o_ready,
  output logic [NUM_DIGITS*DIGIT_W-1:0] o_data,
  output logic [NUM_DIGITS-1:0]         o_enableDigit,
  output logic [NUM_DIGITS-1:0]         o_dots,
  output logic                          o_done
);

  state_e                          state_r, state_s;
  logic [3:0]                      count_r, count_s;
  logic [VALUE_W-1:0]              mag_r, mag_s;
  logic [BCD_W-1:0]                bcd_r, bcd_s;
  logic [BCD_W-1:0]                bcd_adj_s;
  logic                            hex_r, hex_s;
  logic                            sign_r, sign_s;
  logic [NUM_DIGITS-1:0]           dots_lat_r, dots_lat_s;
  logic                            accept_s;
  logic                            negate_s;
  logic [NUM_DIGITS*DIGIT_W-1:0]   data_commit_s;
  logic [NUM_DIGITS-1:0]           en_commit_s;
  logic [NUM_DIGITS-1:0]           dots_commit_s;

  assign o_ready  = (state_r == ST_IDLE);
  assign accept_s = i_valid & o_ready;
  assign negate_s = i_signed & ~i_hexMode & i_value[VALUE_W-1];

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit    (bcd_r[g*DIGIT_W +: DIGIT_W]),
      .adjusted (bcd_adj_s[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Next-state and working-register update
  always_comb begin
    state_s    = state_r;
    count_s    = count_r;
    mag_s      = mag_r;
    bcd_s      = bcd_r;
    hex_s      = hex_r;
    sign_s     = sign_r;
    dots_lat_s = dots_lat_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          hex_s      = i_hexMode;
          sign_s     = negate_s;
          dots_lat_s = i_dots;
          mag_s      = negate_s ? (16'd0 - i_value) : i_value;
          bcd_s      = {BCD_W{1'b0}};
          count_s    = 4'd0;
          state_s    = i_hexMode ? ST_HEX : ST_SHIFT;
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        {bcd_s, mag_s} = {bcd_adj_s[BCD_W-2:0], mag_r, 1'b0};
        count_s        = count_r + 4'd1;
        state_s        = (count_r == 4'd15) ? ST_DONE : ST_SHIFT;
      end
      ST_HEX:  state_s = ST_DONE;
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM and working registers
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_r    <= ST_IDLE;
      count_r    <= 4'd0;
      mag_r      <= {VALUE_W{1'b0}};
      bcd_r      <= {BCD_W{1'b0}};
      hex_r      <= 1'b0;
      sign_r     <= 1'b0;
      dots_lat_r <= {NUM_DIGITS{1'b0}};
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      mag_r      <= mag_s;
      bcd_r      <= bcd_s;
      hex_r      <= hex_s;
      sign_r     <= sign_s;
      dots_lat_r <= dots_lat_s;
    end
  end

  // Values presented to the driver when the conversion completes
  always_comb begin
    data_commit_s = hex_r ? {16'h0000, mag_r} : {12'h000, bcd_r};
    dots_commit_s = dots_lat_r | {sign_r, 7'b000_0000};
    if (BLANK_LEADING) begin
      en_commit_s = lead_enable(data_commit_s);
    end else begin
      en_commit_s = hex_r ? EN_MASK_HEX : EN_MASK_DEC;
    end
  end

  // Output buffer: only the DONE cycle touches it
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_data        <= {(NUM_DIGITS*DIGIT_W){1'b0}};
      o_enableDigit <= {NUM_DIGITS{1'b0}};
      o_dots        <= {NUM_DIGITS{1'b0}};
      o_done        <= 1'b0;
    end else if (state_r == ST_DONE) begin
      o_data        <= data_commit_s;
      o_enableDigit <= en_commit_s;
      o_dots        <= dots_commit_s;
      o_done        <= 1'b1;
    end else begin
      o_done        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_display_value_formatter.sv
// Directed bench for display_value_formatter; a reference model computes every committed
// value and the ready/done timeline, and both blanking variants are checked every cycle.
module tb_display_value_formatter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        valid;
  logic        sgn;
  logic        hex;
  logic [7:0]  dots;

  logic        ready1, done1, ready0, done0;
  logic [31:0] data1, data0;
  logic [7:0]  en1, en0, dots1, dots0;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  // reference model: committed outputs, pending result and its timeline
  logic [31:0] m_data, p_data;
  logic [7:0]  m_en1, m_en0, m_dots, p_en1, p_en0, p_dots;
  int          accept_edge = -100;
  int          commit_edge = -100;

  always #5 clk = ~clk;

  display_value_formatter #(.BLANK_LEADING(1'b1)) dut1 (
    .i_clk(clk), .i_resetn(rst_n), .i_value(value), .i_valid(valid), .i_signed(sgn),
    .i_hexMode(hex), .i_dots(dots), .o_ready(ready1), .o_data(data1),
    .o_enableDigit(en1), .o_dots(dots1), .o_done(done1)
  );

  display_value_formatter #(.BLANK_LEADING(1'b0)) dut0 (
    .i_clk(clk), .i_resetn(rst_n), .i_value(value), .i_valid(valid), .i_signed(sgn),
    .i_hexMode(hex), .i_dots(dots), .o_ready(ready0), .o_data(data0),
    .o_enableDigit(en0), .o_dots(dots0), .o_done(done0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at edge %0d", name, act, exp, edge_cnt);
    end
  endtask

  function automatic void model(input logic [15:0] v, input logic s, input logic h,
                                input logic [7:0] d, output logic [31:0] data,
                                output logic [7:0] e1, output logic [7:0] e0,
                                output logic [7:0] dt);
    logic neg;
    int   mag;
    int   top;
    neg  = s && !h && v[15];
    mag  = neg ? (65536 - int'(v)) : int'(v);
    data = 32'h0;
    if (h) data = {16'h0000, v};
    else begin
      for (int k = 0; k < 5; k++) begin
        data[4*k +: 4] = 4'(mag % 10);
        mag = mag / 10;
      end
    end
    top = 0;
    for (int k = 0; k < 8; k++) if (data[4*k +: 4] != 4'h0) top = k;
    e1 = 8'h00;
    for (int k = 0; k <= top; k++) e1[k] = 1'b1;
    e0 = h ? 8'h0F : 8'h1F;
    dt = d | {neg, 7'h00};
  endfunction

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    logic exp_ready, exp_done;
    if (edge_cnt == commit_edge) begin
      m_data = p_data; m_en1 = p_en1; m_en0 = p_en0; m_dots = p_dots;
    end
    exp_ready = !(edge_cnt >= accept_edge && edge_cnt < commit_edge);
    exp_done  = (edge_cnt == commit_edge);
    check("ready1", {31'h0, ready1}, {31'h0, exp_ready});
    check("done1",  {31'h0, done1},  {31'h0, exp_done});
    check("data1",  data1,           m_data);
    check("en1",    {24'h0, en1},    {24'h0, m_en1});
    check("dots1",  {24'h0, dots1},  {24'h0, m_dots});
    check("ready0", {31'h0, ready0}, {31'h0, exp_ready});
    check("done0",  {31'h0, done0},  {31'h0, exp_done});
    check("data0",  data0,           m_data);
    check("en0",    {24'h0, en0},    {24'h0, m_en0});
    check("dots0",  {24'h0, dots0},  {24'h0, m_dots});
  end

  task automatic model_reset();
    m_data = 32'h0; m_en1 = 8'h0; m_en0 = 8'h0; m_dots = 8'h0;
    accept_edge = -100;
    commit_edge = -100;
  endtask

  // issue one request; pins the model against the hand-computed expectation
  task automatic start_req(input logic [15:0] v, input logic s, input logic h, input logic [7:0] d,
                           input logic [31:0] x_data, input logic [7:0] x_en1,
                           input logic [7:0] x_en0, input logic [7:0] x_dots);
    int waited = 0;
    @(posedge clk); #1;
    while (!ready1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!ready1) check("ready_timeout", 32'h0, 32'h1);
    model(v, s, h, d, p_data, p_en1, p_en0, p_dots);
    check("model_data", p_data, x_data);
    check("model_en1",  {24'h0, p_en1},  {24'h0, x_en1});
    check("model_en0",  {24'h0, p_en0},  {24'h0, x_en0});
    check("model_dots", {24'h0, p_dots}, {24'h0, x_dots});
    accept_edge = edge_cnt + 1;
    commit_edge = accept_edge + (h ? 2 : 17);
    value = v; sgn = s; hex = h; dots = d; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic finish_req(input logic [31:0] x_data, input logic [7:0] x_en1,
                            input logic [7:0] x_en0, input logic [7:0] x_dots);
    int guard = 0;
    while (edge_cnt < commit_edge && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("lit_data", data1, x_data);
    check("lit_en1",  {24'h0, en1},   {24'h0, x_en1});
    check("lit_en0",  {24'h0, en0},   {24'h0, x_en0});
    check("lit_dots", {24'h0, dots1}, {24'h0, x_dots});
    check("lit_done", {31'h0, done1}, 32'h1);
  endtask

  task automatic send(input logic [15:0] v, input logic s, input logic h, input logic [7:0] d,
                      input logic [31:0] x_data, input logic [7:0] x_en1,
                      input logic [7:0] x_en0, input logic [7:0] x_dots);
    start_req(v, s, h, d, x_data, x_en1, x_en0, x_dots);
    finish_req(x_data, x_en1, x_en0, x_dots);
  endtask

  initial begin
    rst_n = 1'b0; value = 16'h0; valid = 1'b0; sgn = 1'b0; hex = 1'b0; dots = 8'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset in the middle of a decimal conversion
    start_req(16'd1234, 1'b0, 1'b0, 8'h00, 32'h00001234, 8'h0F, 8'h1F, 8'h00);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_data",  data1, 32'h0);
    check("rst_ready", {31'h0, ready1}, 32'h1);
    repeat (20) @(posedge clk);

    send(16'd1234,  1'b0, 1'b0, 8'h00, 32'h00001234, 8'h0F, 8'h1F, 8'h00);
    send(16'hFFFF,  1'b0, 1'b0, 8'h00, 32'h00065535, 8'h1F, 8'h1F, 8'h00);
    send(16'd7,     1'b0, 1'b0, 8'h00, 32'h00000007, 8'h01, 8'h1F, 8'h00);
    send(16'hFFFF,  1'b1, 1'b0, 8'h00, 32'h00000001, 8'h01, 8'h1F, 8'h80);
    send(16'h8000,  1'b1, 1'b0, 8'h00, 32'h00032768, 8'h1F, 8'h1F, 8'h80);
    send(16'hBEEF,  1'b0, 1'b1, 8'h04, 32'h0000BEEF, 8'h0F, 8'h0F, 8'h04);
    send(16'h0000,  1'b0, 1'b1, 8'h00, 32'h00000000, 8'h01, 8'h0F, 8'h00);
    send(16'hFFFF,  1'b1, 1'b1, 8'h00, 32'h0000FFFF, 8'h0F, 8'h0F, 8'h00);
    send(16'd100,   1'b1, 1'b0, 8'h01, 32'h00000100, 8'h07, 8'h1F, 8'h01);

    // request while busy is dropped, and input changes mid-conversion are ignored
    start_req(16'd4321, 1'b0, 1'b0, 8'h11, 32'h00004321, 8'h0F, 8'h1F, 8'h11);
    @(posedge clk); #1;
    value = 16'd99; sgn = 1'b1; hex = 1'b1; dots = 8'hFF; valid = 1'b1;
    repeat (6) @(posedge clk);
    #1 valid = 1'b0;
    finish_req(32'h00004321, 8'h0F, 8'h1F, 8'h11);
    repeat (3) @(posedge clk);
    check("hold_data", data1, 32'h00004321);
    send(16'd99,    1'b0, 1'b0, 8'h00, 32'h00000099, 8'h03, 8'h1F, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
